// File: rtl/host_cmd_master_pkg.sv
// Shared encodings for the host command master and the system controller:
// command types, frame opcodes, FSM states and frame/response length helpers.
package host_cmd_master_pkg;

  typedef enum logic [1:0] {
    CmdRegWr  = 2'd0,
    CmdRegRd  = 2'd1,
    CmdAluOp  = 2'd2,
    CmdAluNop = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSend    = 2'd1,
    StWaitRsp = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [7:0] OpRegWr  = 8'hAA;
  localparam logic [7:0] OpRegRd  = 8'hBB;
  localparam logic [7:0] OpAluOp  = 8'hCC;
  localparam logic [7:0] OpAluNop = 8'hDD;

  // Index of the last byte of the outgoing frame.
  function automatic logic [1:0] frame_last(input cmd_type_e t);
    logic [1:0] last;
    case (t)
      CmdRegWr: last = 2'd2;
      CmdRegRd: last = 2'd1;
      CmdAluOp: last = 2'd3;
      default:  last = 2'd1;
    endcase
    return last;
  endfunction

  // Index of the last expected response byte (REG_WR never waits).
  function automatic logic rsp_last(input cmd_type_e t);
    return (t == CmdRegRd) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/host_tmo_cnt.sv
// Response timeout counter: counts enabled cycles since the last clear and
// flags expire once TMO_CYCLES-1 is reached.
module host_tmo_cnt #(
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  assign expire = (cnt_q == CntW'(TMO_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/host_cmd_master.sv
// Host command master: serialises a command into UART frame bytes, collects
// the response bytes LSB first, and reports completion or timeout.
module host_cmd_master
  import host_cmd_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned ALU_FUN_WIDTH = 4,
  parameter int unsigned TMO_CYCLES    = 4096
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [1:0]                CMD_TYPE,
  input  logic [ADDR_SIZE-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_DATA,
  input  logic [DATA_WIDTH-1:0]     CMD_OPB,
  input  logic [ALU_FUN_WIDTH-1:0]  CMD_FUN,
  input  logic                      CMD_VLD,
  output logic                      CMD_RDY,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      TX_RDY,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [2*DATA_WIDTH-1:0]   RSP_DATA,
  output logic                      RSP_VLD,
  output logic                      RSP_TMO
);

  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input cmd_type_e                 t,
    input logic [1:0]                idx,
    input logic [ADDR_SIZE-1:0]      addr,
    input logic [DATA_WIDTH-1:0]     a,
    input logic [DATA_WIDTH-1:0]     b,
    input logic [ALU_FUN_WIDTH-1:0]  fun
  );
    logic [DATA_WIDTH-1:0] res;
    case (t)
      CmdRegWr: res = DATA_WIDTH'(OpRegWr);
      CmdRegRd: res = DATA_WIDTH'(OpRegRd);
      CmdAluOp: res = DATA_WIDTH'(OpAluOp);
      default:  res = DATA_WIDTH'(OpAluNop);
    endcase
    case (t)
      CmdRegWr: begin
        if (idx == 2'd1) res = DATA_WIDTH'(addr);
        if (idx == 2'd2) res = a;
      end
      CmdRegRd: begin
        if (idx == 2'd1) res = DATA_WIDTH'(addr);
      end
      CmdAluOp: begin
        if (idx == 2'd1) res = a;
        if (idx == 2'd2) res = b;
        if (idx == 2'd3) res = DATA_WIDTH'(fun);
      end
      default: begin
        if (idx == 2'd1) res = DATA_WIDTH'(fun);
      end
    endcase
    return res;
  endfunction

  state_e                     state_q;
  cmd_type_e                  type_q;
  logic [ADDR_SIZE-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [DATA_WIDTH-1:0]      opb_q;
  logic [ALU_FUN_WIDTH-1:0]   fun_q;
  logic [1:0]                 idx_q;
  logic                       rsp_cnt_q;
  logic [DATA_WIDTH-1:0]      rx_lo_q;
  logic [2*DATA_WIDTH-1:0]    rsp_data_q;
  logic [DATA_WIDTH-1:0]      tx_data_q;
  logic                       tx_vld_q;
  logic                       cmd_rdy_q;
  logic                       rsp_vld_q;
  logic                       rsp_tmo_q;

  logic tx_last;
  logic tmo_clear;
  logic tmo_en;
  logic tmo_expire;

  assign tx_last   = (idx_q == frame_last(type_q));
  assign tmo_en    = (state_q == StWaitRsp);
  assign tmo_clear = ((state_q == StSend) && TX_RDY && tx_last && (type_q != CmdRegWr)) ||
                     ((state_q == StWaitRsp) && RX_D_VLD);

  host_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo_cnt (
    .CLK    (CLK),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= StIdle;
      type_q     <= CmdRegWr;
      addr_q     <= '0;
      data_q     <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      rsp_cnt_q  <= 1'b0;
      rx_lo_q    <= '0;
      rsp_data_q <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (CMD_VLD) begin
            type_q    <= cmd_type_e'(CMD_TYPE);
            addr_q    <= CMD_ADDR;
            data_q    <= CMD_DATA;
            opb_q     <= CMD_OPB;
            fun_q     <= CMD_FUN;
            idx_q     <= 2'd0;
            rsp_cnt_q <= 1'b0;
            tx_data_q <= frame_byte(cmd_type_e'(CMD_TYPE), 2'd0, CMD_ADDR, CMD_DATA,
                                    CMD_OPB, CMD_FUN);
            tx_vld_q  <= 1'b1;
            cmd_rdy_q <= 1'b0;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (TX_RDY) begin
            if (tx_last) begin
              tx_vld_q <= 1'b0;
              if (type_q == CmdRegWr) begin
                // Writes carry no response payload.
                rsp_data_q <= '0;
                rsp_vld_q  <= 1'b1;
                state_q    <= StDone;
              end else begin
                state_q <= StWaitRsp;
              end
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_q <= frame_byte(type_q, idx_q + 2'd1, addr_q, data_q, opb_q, fun_q);
            end
          end
        end
        StWaitRsp: begin
          // A received byte always beats a coincident timeout.
          if (RX_D_VLD) begin
            if (rsp_cnt_q == rsp_last(type_q)) begin
              rsp_data_q <= rsp_cnt_q ? {RX_P_DATA, rx_lo_q}
                                      : {{DATA_WIDTH{1'b0}}, RX_P_DATA};
              rsp_vld_q  <= 1'b1;
              state_q    <= StDone;
            end else begin
              rx_lo_q   <= RX_P_DATA;
              rsp_cnt_q <= 1'b1;
            end
          end else if (tmo_expire) begin
            rsp_tmo_q <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StDone: begin
          cmd_rdy_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          cmd_rdy_q <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign CMD_RDY   = cmd_rdy_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VLD   = rsp_vld_q;
  assign RSP_TMO   = rsp_tmo_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed bench for host_cmd_master: a table of complete transactions plus
// hand sequences for timeout, byte/timeout collision, stray RX and mid-frame reset.
module tb_host_cmd_master;

  logic        CLK = 1'b0;
  logic        rst;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUN;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_RDY;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TMO;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  host_cmd_master #(
    .DATA_WIDTH    (8),
    .ADDR_SIZE     (4),
    .ALU_FUN_WIDTH (4),
    .TMO_CYCLES    (16)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .CMD_TYPE  (CMD_TYPE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_DATA  (CMD_DATA),
    .CMD_OPB   (CMD_OPB),
    .CMD_FUN   (CMD_FUN),
    .CMD_VLD   (CMD_VLD),
    .CMD_RDY   (CMD_RDY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_RDY    (TX_RDY),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RSP_DATA  (RSP_DATA),
    .RSP_VLD   (RSP_VLD),
    .RSP_TMO   (RSP_TMO)
  );

  // Frame bytes are left-aligned in tx (byte 0 in [31:24]); rx bytes likewise, in arrival order.
  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  fun;
    bit          tog;
    int          ntx;
    logic [31:0] tx;
    int          nrx;
    logic [15:0] rx;
    logic [15:0] rsp;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] fun, input bit tog, input int ntx,
                              input logic [31:0] tx, input int nrx,
                              input logic [15:0] rx, input logic [15:0] rsp);
    vec_t v;
    v.typ = typ; v.addr = addr; v.a = a; v.b = b; v.fun = fun; v.tog = tog;
    v.ntx = ntx; v.tx = tx; v.nrx = nrx; v.rx = rx; v.rsp = rsp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Accept a command and push its frame out, checking every byte while it is held.
  task automatic issue(input vec_t v);
    bit hs;
    int guard;
    chk("cmd_rdy_idle", CMD_RDY, 1);
    CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_DATA = v.a; CMD_OPB = v.b; CMD_FUN = v.fun;
    CMD_VLD  = 1'b1;
    step();
    CMD_VLD  = 1'b0;
    chk("cmd_rdy_busy", CMD_RDY, 0);
    for (int i = 0; i < v.ntx; i++) begin
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 8) begin
        TX_RDY = v.tog ? guard[0] : 1'b1;
        chk("tx_vld", TX_D_VLD, 1);
        chk("tx_byte", TX_P_DATA, v.tx[31-8*i -: 8]);
        hs = TX_RDY;
        step();
        guard++;
      end
    end
    TX_RDY = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    if (v.nrx > 0) begin
      chk("tx_vld_after_frame", TX_D_VLD, 0);
      repeat (2) begin
        chk("rsp_vld_waiting", RSP_VLD, 0);
        step();
      end
      for (int j = 0; j < v.nrx; j++) begin
        RX_D_VLD  = 1'b1;
        RX_P_DATA = v.rx[15-8*j -: 8];
        step();
        RX_D_VLD  = 1'b0;
      end
    end
    chk("rsp_vld", RSP_VLD, 1);
    chk("rsp_tmo_in_done", RSP_TMO, 0);
    chk("rsp_data", RSP_DATA, v.rsp);
    chk("cmd_rdy_in_done", CMD_RDY, 0);
    step();
    chk("cmd_rdy_after_done", CMD_RDY, 1);
    chk("rsp_vld_one_cycle", RSP_VLD, 0);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = mk(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 3, 32'hAA035A00, 0, 16'h0000, 16'h0000);
    vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 2, 32'hBB020000, 1, 16'h8100, 16'h0081);
    vecs[2] = mk(2'd2, 4'h0, 8'h10, 8'h20, 4'h2, 1'b0, 4, 32'hCC102002, 2, 16'h0002, 16'h0200);
    vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 2, 32'hDD000000, 2, 16'h3412, 16'h1234);
    vecs[4] = mk(2'd0, 4'hF, 8'hC3, 8'h00, 4'h0, 1'b0, 3, 32'hAA0FC300, 0, 16'h0000, 16'h0000);
    vecs[5] = mk(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 2, 32'hBB0A0000, 1, 16'hFF00, 16'h00FF);
    vecs[6] = mk(2'd2, 4'h0, 8'hFF, 8'h01, 4'hF, 1'b0, 4, 32'hCCFF010F, 2, 16'hABCD, 16'hCDAB);

    rst = 1'b1; CMD_TYPE = '0; CMD_ADDR = '0; CMD_DATA = '0; CMD_OPB = '0; CMD_FUN = '0;
    CMD_VLD = 1'b0; TX_RDY = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    repeat (3) step();
    chk("rst_cmd_rdy", CMD_RDY, 1);
    chk("rst_tx_vld", TX_D_VLD, 0);
    chk("rst_tx_data", TX_P_DATA, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_rsp_vld", RSP_VLD, 0);
    chk("rst_rsp_tmo", RSP_TMO, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_rdy", CMD_RDY, 1);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Timeout: ALU_NOP with no response; RSP_DATA keeps the previous 0xCDAB.
    v = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 2, 32'hDD000000, 0, 16'h0000, 16'h0000);
    issue(v);
    for (int j = 0; j < 16; j++) begin
      chk("tmo_early", RSP_TMO, 0);
      chk("tmo_no_vld", RSP_VLD, 0);
      step();
    end
    chk("tmo_pulse", RSP_TMO, 1);
    chk("tmo_vld_low", RSP_VLD, 0);
    chk("tmo_rsp_data_kept", RSP_DATA, 16'hCDAB);
    chk("tmo_cmd_rdy", CMD_RDY, 1);
    step();
    chk("tmo_one_cycle", RSP_TMO, 0);

    // Final byte lands in the very cycle the counter expires.
    issue(v);
    repeat (2) step();
    RX_D_VLD = 1'b1; RX_P_DATA = 8'h77;
    step();
    RX_D_VLD = 1'b0;
    repeat (15) begin
      chk("race_no_tmo", RSP_TMO, 0);
      step();
    end
    RX_D_VLD = 1'b1; RX_P_DATA = 8'h99;
    step();
    RX_D_VLD = 1'b0;
    chk("race_rsp_vld", RSP_VLD, 1);
    chk("race_rsp_tmo", RSP_TMO, 0);
    chk("race_rsp_data", RSP_DATA, 16'h9977);
    step();
    chk("race_tmo_after", RSP_TMO, 0);
    chk("race_cmd_rdy", CMD_RDY, 1);

    // Stray RX bytes in IDLE.
    RX_D_VLD = 1'b1; RX_P_DATA = 8'hEE;
    repeat (3) begin
      step();
      chk("stray_no_vld", RSP_VLD, 0);
      chk("stray_no_tmo", RSP_TMO, 0);
      chk("stray_cmd_rdy", CMD_RDY, 1);
      chk("stray_rsp_data", RSP_DATA, 16'h9977);
    end
    RX_D_VLD = 1'b0;
    run_vec(mk(2'd1, 4'h5, 8'h00, 8'h00, 4'h0, 1'b0, 2, 32'hBB050000, 1, 16'h4200, 16'h0042));

    // Reset after the second frame byte of an ALU_OP.
    v = mk(2'd2, 4'h0, 8'h11, 8'h22, 4'h3, 1'b0, 4, 32'hCC112203, 2, 16'h0000, 16'h0000);
    chk("mid_cmd_rdy", CMD_RDY, 1);
    CMD_TYPE = v.typ; CMD_DATA = v.a; CMD_OPB = v.b; CMD_FUN = v.fun; CMD_VLD = 1'b1;
    step();
    CMD_VLD = 1'b0;
    chk("mid_b0", TX_P_DATA, 8'hCC);
    step();
    chk("mid_b1", TX_P_DATA, 8'h11);
    step();
    chk("mid_b2", TX_P_DATA, 8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tx_vld", TX_D_VLD, 0);
    chk("mid_rst_cmd_rdy", CMD_RDY, 1);
    chk("mid_rst_rsp_data", RSP_DATA, 0);
    for (int j = 0; j < 20; j++) begin
      RX_D_VLD = j[0]; RX_P_DATA = 8'h5C;
      step();
      chk("mid_rst_no_vld", RSP_VLD, 0);
      chk("mid_rst_no_tmo", RSP_TMO, 0);
    end
    RX_D_VLD = 1'b0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each UART byte.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, register-file address width.
REQ-003 SHALL have parameter ALU_FUN_WIDTH, default 4, ALU function code width.
REQ-004 SHALL have parameter TMO_CYCLES, default 4096, response timeout in CLK cycles.
REQ-005 SHALL have ports:
- CLK  in  1  sole clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- CMD_TYPE  in  2  command type: 0 REG_WR, 1 REG_RD, 2 ALU_OP, 3 ALU_NOP.
- CMD_ADDR  in  ADDR_SIZE  register address.
- CMD_DATA  in  DATA_WIDTH  write data, or operand A.
- CMD_OPB  in  DATA_WIDTH  operand B.
- CMD_FUN  in  ALU_FUN_WIDTH  ALU function.
- CMD_VLD  in  1  command request.
- CMD_RDY  out  1  command accepted when CMD_VLD and CMD_RDY are both high.
- TX_P_DATA  out  DATA_WIDTH  byte to the UART transmitter.
- TX_D_VLD  out  1  byte valid.
- TX_RDY  in  1  transmitter accepts the byte.
- RX_P_DATA  in  DATA_WIDTH  byte from the UART receiver.
- RX_D_VLD  in  1  single-cycle receive strobe.
- RSP_DATA  out  2*DATA_WIDTH  assembled response.
- RSP_VLD  out  1  one-cycle pulse when the command completes.
- RSP_TMO  out  1  one-cycle pulse when the command times out.

Function
REQ-006 SHALL use the FSM states IDLE, SEND, WAIT_RSP and DONE; CMD_RDY SHALL be high only in IDLE.
REQ-007 On acceptance, SHALL register all CMD_* fields and go to SEND on the next cycle.
REQ-008 Frame bytes SHALL be sent in this order:
- REG_WR: 0xAA, addr (zero-extended), data.
- REG_RD: 0xBB, addr.
- ALU_OP: 0xCC, A, B, fun (zero-extended).
- ALU_NOP: 0xDD, fun.
REQ-009 In SEND, TX_D_VLD SHALL stay high and TX_P_DATA stable until TX_RDY is high; the byte index SHALL advance on each cycle where TX_D_VLD and TX_RDY are both high.
REQ-010 After the last byte, REG_WR SHALL go directly to DONE; the other types SHALL go to WAIT_RSP.
REQ-011 Expected response byte count: REG_RD 1; ALU_OP and ALU_NOP 2.
REQ-012 Response bytes SHALL arrive LSB first.
REQ-013 For REG_RD, RSP_DATA SHALL hold the received byte zero-extended.
REQ-014 In WAIT_RSP, each RX_D_VLD SHALL store one byte; after the final byte the FSM SHALL go to DONE.
REQ-015 A timeout counter SHALL clear on entry to WAIT_RSP and on each RX_D_VLD; when it reaches TMO_CYCLES-1 the FSM SHALL pulse RSP_TMO, leave RSP_DATA unchanged, and return to IDLE.
REQ-016 If the final RX_D_VLD and the timeout occur in the same cycle, the byte SHALL win: RSP_VLD pulses and RSP_TMO does not.
REQ-017 DONE SHALL last one cycle: RSP_VLD pulses there, and the FSM then returns to IDLE.
REQ-018 Latency from entering DONE to CMD_RDY high SHALL be 1 cycle.
REQ-019 RX_D_VLD outside WAIT_RSP SHALL be ignored.
REQ-020 CMD_VLD outside IDLE SHALL be ignored; there is no command queue.
REQ-021 RSP_VLD and RSP_TMO SHALL never be high in the same cycle.

Reset
REQ-022 While rst is high on a CLK edge, the following SHALL clear: state to IDLE, byte index, response counter, timeout counter, RSP_DATA, and captured command fields.
REQ-023 Output reset values SHALL be: CMD_RDY 1 (IDLE), TX_D_VLD 0, TX_P_DATA 0, RSP_DATA 0, RSP_VLD 0, RSP_TMO 0.
REQ-024 Reset asserted during SEND or WAIT_RSP SHALL abandon the frame with no RSP_VLD or RSP_TMO pulse.

Structure
REQ-025 The command opcodes (0xAA, 0xBB, 0xCC, 0xDD), the CMD_TYPE encodings and the FSM state encoding SHALL live in a shared package, shared with the system controller.
REQ-026 The timeout counter SHALL be a sub-module, host_tmo_cnt, with inputs clear and enable and output expire.

Verification
REQ-027 REG_WR, addr 0x3, data 0x5A, TX_RDY held high -> TX bytes AA,03,5A on consecutive cycles; RSP_VLD pulses with RSP_DATA 0x0000; CMD_RDY high again 1 cycle after DONE.
REQ-028 REG_RD, addr 0x2, TX_RDY toggling every other cycle -> bytes BB,02 each held until TX_RDY; RX byte 0x81 -> RSP_VLD with RSP_DATA 0x0081.
REQ-029 ALU_OP, A 0x10, B 0x20, fun 0x2 -> bytes CC,10,20,02; RX bytes 0x00 then 0x02 -> RSP_DATA 0x0200.
REQ-030 ALU_NOP, fun 0x0, TMO_CYCLES 16, no RX -> RSP_TMO pulses 16 cycles after WAIT_RSP entry; RSP_VLD stays 0; RSP_DATA unchanged.
REQ-031 Second RX byte arriving in the same cycle as the timeout -> RSP_VLD 1 and RSP_TMO 0.
REQ-032 Stray RX bytes while in IDLE -> ignored.
REQ-033 rst asserted after the second TX byte of an ALU_OP -> next cycle IDLE, TX_D_VLD 0, no response pulses.
